// File: rtl/cv_line_sched_if.sv
// Bus bundle between the line scheduler and its surroundings: the
// display timing source, the line-buffer clear engine and the BG renderer.
// The slave modport is the scheduler's view; master is the environment's view.
interface cv_line_sched_if;
  // Display timing side
  logic       line_req;
  logic [9:0] line_num;
  logic [1:0] layer_en;
  logic [9:0] bg0_xoff;
  logic [9:0] bg0_yoff;
  logic [9:0] bg1_xoff;
  logic [9:0] bg1_yoff;

  // Clear engine handshake
  logic       clr_start;
  logic       clr_done;

  // Renderer handshake and parameters
  logic       bg_cs;
  logic [9:0] bg_v_count;
  logic [9:0] bg_xoffset;
  logic [9:0] bg_yoffset;
  logic [1:0] bg_l_bank;
  logic       bg_render_end;

  // Display bank and status
  logic [1:0] disp_bank;
  logic       busy;
  logic       overrun;
  logic       ovr_clr;

  modport slave (
    input  line_req, line_num, layer_en,
    input  bg0_xoff, bg0_yoff, bg1_xoff, bg1_yoff,
    input  clr_done, bg_render_end, ovr_clr,
    output clr_start, bg_cs, bg_v_count, bg_xoffset, bg_yoffset,
    output bg_l_bank, disp_bank, busy, overrun
  );

  modport master (
    output line_req, line_num, layer_en,
    output bg0_xoff, bg0_yoff, bg1_xoff, bg1_yoff,
    output clr_done, bg_render_end, ovr_clr,
    input  clr_start, bg_cs, bg_v_count, bg_xoffset, bg_yoffset,
    input  bg_l_bank, disp_bank, busy, overrun
  );
endinterface

// File: rtl/cv_line_sched.sv
// Per-line BG scheduler. On each hblank request it snapshots the line
// parameters, rotates the line-buffer bank, runs the clear engine and then
// up to two BG layer render passes, with a watchdog on every phase and a
// sticky overrun flag for late requests or stalled phases.
// All outputs are registered; next-output values are derived from the
// next state so each output matches the state it belongs to.
module cv_line_sched #(
  parameter logic [9:0] LINE_MAX = 10'd239,
  parameter logic [9:0] TIMEOUT  = 10'd1000
) (
  input logic            clk,
  input logic            reset,
  cv_line_sched_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_L0   = 3'd2,
    ST_G0   = 3'd3,
    ST_L1   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Phases guarded by the watchdog counter.
  function automatic logic is_phase(input state_t s);
    return (s == ST_CLR) || (s == ST_L0) || (s == ST_L1);
  endfunction

  state_t     state_r;
  state_t     state_s;

  // Shadow copies of the line parameters, frozen for the line in progress.
  logic [9:0] tgt_r, tgt_s;
  logic [1:0] en_r, en_s;
  logic [9:0] x0_r, x0_s;
  logic [9:0] y0_r, y0_s;
  logic [9:0] x1_r, x1_s;
  logic [9:0] y1_r, y1_s;
  logic [1:0] wr_bank_r, wr_bank_s;

  logic [9:0] phase_cnt_r;

  // Registered outputs and their next values.
  logic       clr_start_r, clr_start_s;
  logic       bg_cs_r, bg_cs_s;
  logic       busy_r, busy_s;
  logic       overrun_r, overrun_s;
  logic [9:0] xoff_r, xoff_s;
  logic [9:0] yoff_r, yoff_s;
  logic [1:0] disp_bank_r, disp_bank_s;

  // Event decode.
  logic accept_s;
  logic late_req_s;
  logic phase_done_s;
  logic timeout_s;
  logic ovr_set_s;

  // Classify this cycle's events: accepted/late requests, phase completion, watchdog expiry.
  always_comb begin
    accept_s     = (state_r == ST_IDLE) && bus.line_req;
    late_req_s   = (state_r != ST_IDLE) && bus.line_req;
    phase_done_s = ((state_r == ST_CLR) && bus.clr_done) ||
                   (((state_r == ST_L0) || (state_r == ST_L1)) && bus.bg_render_end);
    // A completion on the last allowed cycle still counts as on time.
    timeout_s    = is_phase(state_r) && !phase_done_s &&
                   (phase_cnt_r == (TIMEOUT - 10'd1));
    ovr_set_s    = late_req_s || timeout_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; stray handshakes outside their own phase are ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.line_req) begin
          state_s = ST_CLR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLR: begin
        if (bus.clr_done) begin
          if (en_r[0]) begin
            state_s = ST_L0;
          end else if (en_r[1]) begin
            state_s = ST_L1;
          end else begin
            state_s = ST_DONE;
          end
        end else if (timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CLR;
        end
      end
      ST_L0: begin
        if (bus.bg_render_end) begin
          state_s = ST_G0;
        end else if (timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_L0;
        end
      end
      ST_G0: begin
        if (en_r[1]) begin
          state_s = ST_L1;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_L1: begin
        if (bus.bg_render_end || timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_L1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next shadow values: only an accepted request may load them.
  always_comb begin
    tgt_s     = tgt_r;
    en_s      = en_r;
    x0_s      = x0_r;
    y0_s      = y0_r;
    x1_s      = x1_r;
    y1_s      = y1_r;
    wr_bank_s = wr_bank_r;
    if (accept_s) begin
      if (bus.line_num >= LINE_MAX) begin
        tgt_s = 10'd0;
      end else begin
        tgt_s = bus.line_num + 10'd1;
      end
      en_s      = bus.layer_en;
      x0_s      = bus.bg0_xoff;
      y0_s      = bus.bg0_yoff;
      x1_s      = bus.bg1_xoff;
      y1_s      = bus.bg1_yoff;
      wr_bank_s = wr_bank_r + 2'd1;
    end else begin
      wr_bank_s = wr_bank_r;
    end
  end

  // Shadow and bank registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_r     <= 10'd0;
      en_r      <= 2'd0;
      x0_r      <= 10'd0;
      y0_r      <= 10'd0;
      x1_r      <= 10'd0;
      y1_r      <= 10'd0;
      wr_bank_r <= 2'd0;
    end else begin
      tgt_r     <= tgt_s;
      en_r      <= en_s;
      x0_r      <= x0_s;
      y0_r      <= y0_s;
      x1_r      <= x1_s;
      y1_r      <= y1_s;
      wr_bank_r <= wr_bank_s;
    end
  end

  // Watchdog: restarts on entry to each guarded phase, counts cycles spent in it.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt_r <= 10'd0;
    end else if (is_phase(state_s) && (state_s != state_r)) begin
      phase_cnt_r <= 10'd0;
    end else if (is_phase(state_r)) begin
      phase_cnt_r <= phase_cnt_r + 10'd1;
    end else begin
      phase_cnt_r <= 10'd0;
    end
  end

  // Next output values decoded from the next state and next shadows.
  always_comb begin
    clr_start_s = accept_s;
    busy_s      = (state_s != ST_IDLE);
    bg_cs_s     = (state_s == ST_L0) || (state_s == ST_L1);
    disp_bank_s = wr_bank_s - 2'd1;
    if ((state_s == ST_L0) || (state_s == ST_G0)) begin
      xoff_s = x0_s;
      yoff_s = y0_s;
    end else begin
      xoff_s = x1_s;
      yoff_s = y1_s;
    end
    // Setting the flag takes priority over clearing it.
    if (ovr_set_s) begin
      overrun_s = 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_start_r <= 1'b0;
      busy_r      <= 1'b0;
      bg_cs_r     <= 1'b0;
      disp_bank_r <= 2'd3;
      xoff_r      <= 10'd0;
      yoff_r      <= 10'd0;
      overrun_r   <= 1'b0;
    end else begin
      clr_start_r <= clr_start_s;
      busy_r      <= busy_s;
      bg_cs_r     <= bg_cs_s;
      disp_bank_r <= disp_bank_s;
      xoff_r      <= xoff_s;
      yoff_r      <= yoff_s;
      overrun_r   <= overrun_s;
    end
  end

  assign bus.clr_start  = clr_start_r;
  assign bus.bg_cs      = bg_cs_r;
  assign bus.bg_v_count = tgt_r;
  assign bus.bg_xoffset = xoff_r;
  assign bus.bg_yoffset = yoff_r;
  assign bus.bg_l_bank  = wr_bank_r;
  assign bus.disp_bank  = disp_bank_r;
  assign bus.busy       = busy_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: doc/cv_line_sched.md
CV_LINE_SCHED -- requirements
Module: cv_line_sched

Interface
REQ-001 The block SHALL have parameter LINE_MAX, default 10'd239, giving the last visible line number.
REQ-002 The block SHALL have parameter TIMEOUT, default 10'd1000, giving the maximum cycles allowed per phase before abort.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 line_req  in  1  one-cycle pulse at start of hblank for displayed line line_num.
REQ-006 line_num  in  10  line currently being displayed.
REQ-007 layer_en  in  2  per-BG-layer enable; bit0 = layer 0, bit1 = layer 1.
REQ-008 bg0_xoff, bg0_yoff, bg1_xoff, bg1_yoff  in  10 each  per-layer scroll offsets.
REQ-009 clr_start  out  1  one-cycle pulse requesting the line-buffer clear engine.
REQ-010 clr_done  in  1  clear engine completion pulse.
REQ-011 bg_cs  out  1  BG renderer select; renderer restarts whenever this is low.
REQ-012 bg_v_count, bg_xoffset, bg_yoffset  out  10 each  renderer line and offsets.
REQ-013 bg_l_bank  out  2  line-buffer bank being written.
REQ-014 bg_render_end  in  1  renderer done level; valid only while bg_cs = 1.
REQ-015 disp_bank  out  2  line-buffer bank the display reads.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 overrun  out  1  sticky error flag.
REQ-018 ovr_clr  in  1  clears overrun.

Function
REQ-019 States SHALL be IDLE, CLR, L0, G0, L1, DONE.
- IDLE: waiting for a line.
- CLR: clear engine running.
- L0 / L1: layer 0 / layer 1 rendering.
- G0: one-cycle gap with bg_cs low.
- DONE: one cycle, then IDLE.
REQ-020 On line_req in IDLE, the block SHALL:
- latch the target line = line_num + 1, wrapping to 0 when line_num >= LINE_MAX;
- latch all four offsets and layer_en into shadow registers;
- advance wr_bank by 1 modulo 4;
- pulse clr_start the next cycle and enter CLR.
REQ-021 disp_bank SHALL equal wr_bank - 1 modulo 4 at all times, updating in the same cycle as wr_bank.
REQ-022 In CLR, clr_done SHALL move the FSM to L0 if shadow layer_en[0] is set, else to L1 if layer_en[1] is set, else to DONE.
REQ-023 bg_cs SHALL be 1 exactly in L0 and L1, with no cycle of bg_cs = 1 between the two layers.
REQ-024 bg_xoffset and bg_yoffset SHALL present the shadow offsets of layer 0 in L0 and G0, and of layer 1 otherwise.
REQ-025 bg_v_count SHALL present the latched target line, and bg_l_bank SHALL present wr_bank.
REQ-026 In L0, bg_render_end = 1 SHALL move the FSM to G0.
REQ-027 G0 SHALL go to L1 if shadow layer_en[1] is set, else to DONE.
REQ-028 In L1, bg_render_end = 1 SHALL move the FSM to DONE.
REQ-029 A phase cycle counter SHALL reset on entry to CLR, L0 and L1.
REQ-030 If the phase counter reaches TIMEOUT, the block SHALL set overrun and go to DONE, dropping bg_cs the next cycle.
REQ-031 line_req while busy SHALL set overrun and be otherwise ignored, with no change to bank, shadows or state.
REQ-032 line_req in DONE SHALL be treated as busy.
REQ-033 When ovr_clr and an overrun-setting event occur in the same cycle, set SHALL win.
REQ-034 ovr_clr alone SHALL clear overrun the next cycle.
REQ-035 Shadow registers SHALL change only on an accepted line_req, so register writes mid-line do not affect the line in progress.
REQ-036 clr_done or bg_render_end outside its own state SHALL be ignored.

Reset
REQ-037 On reset, the block SHALL set:
- state = IDLE and wr_bank = 0, so disp_bank = 3;
- bg_cs = 0, clr_start = 0, busy = 0, overrun = 0;
- all 10-bit outputs and shadows to 0.
REQ-038 Reset asserted mid-operation SHALL return the block to the reset state at the next edge, dropping bg_cs that cycle.

Verification
REQ-039 Both layers: line_req with line_num = 5, layer_en = 2'b11; clr_done after 4 cycles; render_end after 60 cycles per layer -> clr_start pulses once; bg_v_count = 6; bg_cs high in L0, low exactly 1 cycle (G0), high in L1; bg_l_bank = 1, disp_bank = 0; busy falls after DONE.
REQ-040 Wrap: line_num = 239 -> bg_v_count = 0. Also, four consecutive lines -> bg_l_bank sequence 1, 2, 3, 0.
REQ-041 Layer skip: layer_en = 2'b10 -> CLR goes directly to L1 with layer-1 offsets. layer_en = 2'b00 -> CLR goes to DONE with no bg_cs assertion.
REQ-042 Timeout: render_end never asserted in L0 -> overrun = 1 after TIMEOUT cycles; FSM reaches DONE/IDLE; the next line_req is accepted.
REQ-043 Overrun and shadowing:
- line_req during L1 -> overrun = 1, bank unchanged, current line completes normally;
- simultaneous ovr_clr and new overrun -> overrun stays 1;
- bg0_xoff changed during L0 -> bg_xoffset unchanged.
REQ-044 Reset pulse during L1 -> next cycle bg_cs = 0, busy = 0, bg_l_bank = 0, disp_bank = 3.
